fetch_controller: RTL and testbench

Instruction-fetch sequencer that drives the program counter's `selector`/`instruction` inputs and consumes its `out` value. Each cycle it decides whether the program counter advances, holds or loads a branch target. It reads instruction memory through a single-outstanding request/response handshake and presents fetched words to the decoder with valid/ready flow control. It sits between the program counter, instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_hold_register.sv | 54 +++++
 rtl/fetch_controller.sv | 153 +++++++++++++++
 tb/tb_fetch_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared selector codes and state encoding for the instruction-fetch sequencer.
package fetch_pkg;

  localparam logic [1:0] SELECTOR_NEXT_INSTRUCTION = 2'd0;
  localparam logic [1:0] SELECTOR_KEEP_INSTRUCTION = 2'd1;
  localparam logic [1:0] SELECTOR_LOAD_INSTRUCTION = 2'd2;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_register.sv
// Output register presenting a fetched word and its address to decode.
// Capture loads a new word and raises valid; clear drops valid once the word is consumed.
module fetch_hold_register #(
  parameter int WORD_SIZE = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 capture,
  input  logic                 clear,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [WORD_SIZE-1:0] address_in,
  output logic                 valid,
  output logic [WORD_SIZE-1:0] data,
  output logic [WORD_SIZE-1:0] address
);

  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [WORD_SIZE-1:0] address_q, address_d;

  // Next-value selection: capture wins, clear only drops valid so data stays readable.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    address_d = address_q;
    if (capture) begin
      valid_d   = 1'b1;
      data_d    = data_in;
      address_d = address_in;
    end else if (clear) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register update with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      data_q    <= {WORD_SIZE{1'b0}};
      address_q <= {WORD_SIZE{1'b0}};
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      address_q <= address_d;
    end
  end

  assign valid   = valid_q;
  assign data    = data_q;
  assign address = address_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: steers the program counter, issues single-outstanding
// memory reads and presents words to decode. Optional halt-on-word via FETCH_HALT_EN.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                   WORD_SIZE = 15,
  parameter logic [WORD_SIZE-1:0] HALT_WORD = {WORD_SIZE{1'b1}}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [1:0]           pc_selector,
  output logic [WORD_SIZE-1:0] pc_instruction,
  output logic                 mem_read,
  output logic [WORD_SIZE-1:0] mem_address,
  input  logic                 mem_valid,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 branch_valid,
  input  logic [WORD_SIZE-1:0] branch_target,
  output logic                 instr_valid,
  output logic [WORD_SIZE-1:0] instr_data,
  output logic [WORD_SIZE-1:0] instr_address,
  input  logic                 instr_ready,
  output logic                 halted
);

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
  logic                 capture_s;
  logic                 clear_s;
  logic                 halt_hit_s;

  // Folds to constant 0 when the halt feature is not built.
  assign halt_hit_s = HALT_EN & (instr_data == HALT_WORD);

  // Next-state and combinational outputs toward PC and memory.
  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    pc_selector    = SELECTOR_KEEP_INSTRUCTION;
    pc_instruction = {WORD_SIZE{1'b0}};
    mem_read       = 1'b0;
    mem_address    = {WORD_SIZE{1'b0}};
    capture_s      = 1'b0;
    clear_s        = 1'b0;
    case (state_q)
      ST_START: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (branch_valid) begin
          pc_selector    = SELECTOR_LOAD_INSTRUCTION;
          pc_instruction = branch_target;
        end else begin
          mem_read    = 1'b1;
          mem_address = pc;
          req_addr_d  = pc;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A redirect while waiting must still retire the outstanding response.
        if (branch_valid) begin
          pc_selector    = SELECTOR_LOAD_INSTRUCTION;
          pc_instruction = branch_target;
          if (mem_valid) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (mem_valid) begin
          capture_s   = 1'b1;
          pc_selector = SELECTOR_NEXT_INSTRUCTION;
          state_d     = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (branch_valid) begin
          pc_selector    = SELECTOR_LOAD_INSTRUCTION;
          pc_instruction = branch_target;
          clear_s        = 1'b1;
          state_d        = ST_FETCH;
        end else if (instr_ready) begin
          clear_s = 1'b1;
          state_d = halt_hit_s ? ST_HALTED : ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (mem_valid) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALTED: begin
        if (branch_valid) begin
          pc_selector    = SELECTOR_LOAD_INSTRUCTION;
          pc_instruction = branch_target;
          state_d        = ST_FETCH;
        end else begin
          state_d = ST_HALTED;
        end
      end
`endif
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // State and request-address registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_START;
      req_addr_q <= {WORD_SIZE{1'b0}};
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_hold_register #(
    .WORD_SIZE (WORD_SIZE)
  ) u_hold (
    .clock      (clock),
    .reset      (reset),
    .capture    (capture_s),
    .clear      (clear_s),
    .data_in    (mem_data),
    .address_in (req_addr_q),
    .valid      (instr_valid),
    .data       (instr_data),
    .address    (instr_address)
  );

`ifdef FETCH_HALT_EN
  assign halted = (state_q == ST_HALTED);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized self-checking bench for fetch_controller with a PC model, a memory model
// and a transaction-level reference of the fetch protocol.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int W = 15;
  localparam logic [W-1:0] HALT = {W{1'b1}};
`ifdef FETCH_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic [W-1:0] pc;
  logic [1:0]   pc_selector;
  logic [W-1:0] pc_instruction;
  logic         mem_read;
  logic [W-1:0] mem_address;
  logic         mem_valid;
  logic [W-1:0] mem_data;
  logic         branch_valid;
  logic [W-1:0] branch_target;
  logic         instr_valid;
  logic [W-1:0] instr_data;
  logic [W-1:0] instr_address;
  logic         instr_ready;
  logic         halted;

  fetch_controller #(.WORD_SIZE(W)) dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_selector(pc_selector),
    .pc_instruction(pc_instruction), .mem_read(mem_read), .mem_address(mem_address),
    .mem_valid(mem_valid), .mem_data(mem_data), .branch_valid(branch_valid),
    .branch_target(branch_target), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_address(instr_address), .instr_ready(instr_ready), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks_n;
  int failures_n;
  int cyc;

  // environment: program counter and memory
  logic [W-1:0] pc_m;
  bit           mp_pend;
  int           mp_cnt;
  logic [W-1:0] mp_addr;
  int           lat_cfg;
  bit           plant_halt;

  // reference: transaction flags
  bit           m_started, m_out, m_drop, m_have, m_halt;
  logic [W-1:0] m_req, m_addr, m_data;

  logic [W-1:0] deliv_addr[$];
  int           deliv_cyc[$];
  int           read_n;
  logic [W-1:0] last_read_addr;
  int           halted_cyc;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (plant_halt && a == 15'd2) return HALT;
    return a + 15'h1000;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      failures_n++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_started = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_have = 1'b0; m_halt = 1'b0;
    m_req = '0; m_addr = '0; m_data = '0;
    pc_m = '0; mp_pend = 1'b0; mp_cnt = 0; mp_addr = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    check_val({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    check_val({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check_val({tag, "_instr_data"}, 32'(instr_data), 32'd0);
    check_val({tag, "_instr_address"}, 32'(instr_address), 32'd0);
    check_val({tag, "_halted"}, 32'(halted), 32'd0);
    check_val({tag, "_pc_selector"}, 32'(pc_selector), 32'(SELECTOR_KEEP_INSTRUCTION));
    check_val({tag, "_pc_instruction"}, 32'(pc_instruction), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
    mem_valid = 1'b0; mem_data = '0; pc = '0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_reset_outputs("reset");
      @(posedge clock);
    end
    #1 reset = 1'b1;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance models at posedge.
  task automatic run_cycle(input bit bv, input logic [W-1:0] tgt, input bit rdy);
    logic [1:0]   e_sel;
    bit           e_read;
    bit           mv;
    bit           o_read;
    logic [W-1:0] o_addr;
    logic [1:0]   o_sel;
    logic [W-1:0] o_pci;

    mv = mp_pend && (mp_cnt == 1);
    branch_valid = bv; branch_target = tgt; instr_ready = rdy;
    mem_valid = mv; mem_data = mv ? mem_word(mp_addr) : '0; pc = pc_m;

    e_sel  = SELECTOR_KEEP_INSTRUCTION;
    e_read = 1'b0;
    if (m_started && !(m_out && m_drop)) begin
      if (bv) e_sel = SELECTOR_LOAD_INSTRUCTION;
      else if (!m_halt && !m_have && !m_out) e_read = 1'b1;
      else if (!m_halt && !m_have && m_out && mv) e_sel = SELECTOR_NEXT_INSTRUCTION;
    end

    @(negedge clock);
    check_val("mem_read", 32'(mem_read), 32'(e_read));
    if (e_read) check_val("mem_address", 32'(mem_address), 32'(pc_m));
    check_val("pc_selector", 32'(pc_selector), 32'(e_sel));
    if (e_sel == SELECTOR_LOAD_INSTRUCTION) check_val("pc_instruction", 32'(pc_instruction), 32'(tgt));
    check_val("instr_valid", 32'(instr_valid), 32'(m_have));
    if (m_have) begin
      check_val("instr_data", 32'(instr_data), 32'(m_data));
      check_val("instr_address", 32'(instr_address), 32'(m_addr));
    end
    check_val("halted", 32'(halted), 32'(m_halt));
    o_read = mem_read; o_addr = mem_address; o_sel = pc_selector; o_pci = pc_instruction;
    if (o_read) begin read_n++; last_read_addr = o_addr; end
    if (m_have && rdy) begin deliv_addr.push_back(m_addr); deliv_cyc.push_back(cyc); end
    if (halted) halted_cyc++;

    @(posedge clock);
    if (!m_started) m_started = 1'b1;
    else if (m_halt) begin
      if (bv) m_halt = 1'b0;
    end else if (m_have) begin
      if (!bv && rdy && HALT_ON && m_data == HALT) m_halt = 1'b1;
      if (bv || rdy) m_have = 1'b0;
    end else if (m_out) begin
      if (mv) begin
        if (!m_drop && !bv) begin m_have = 1'b1; m_addr = m_req; m_data = mem_word(m_req); end
        m_out = 1'b0; m_drop = 1'b0;
      end else if (bv) m_drop = 1'b1;
    end else if (!bv) begin
      m_out = 1'b1; m_req = pc_m;
    end

    if (o_sel == SELECTOR_NEXT_INSTRUCTION) pc_m = pc_m + 15'd1;
    else if (o_sel == SELECTOR_LOAD_INSTRUCTION) pc_m = o_pci;
    if (mp_pend) begin
      if (mp_cnt == 1) mp_pend = 1'b0;
      else mp_cnt--;
    end
    if (o_read) begin
      mp_pend = 1'b1; mp_addr = o_addr;
      mp_cnt = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int r0;
    logic [W-1:0] tgt;
    checks_n = 0; failures_n = 0; cyc = 0; read_n = 0; halted_cyc = 0;
    last_read_addr = '0; lat_cfg = 1; plant_halt = 1'b0;
    reset = 1'b1;
    #1;
    apply_reset();

    // first request lands on the second cycle after release
    run_cycle(1'b0, '0, 1'b1);
    check_val("first_cycle_reads", 32'(read_n), 32'd0);
    run_cycle(1'b0, '0, 1'b1);
    check_val("second_cycle_reads", 32'(read_n), 32'd1);
    check_val("first_req_addr", 32'(last_read_addr), 32'd0);

    // sequential fetch, latency 1, always ready
    for (int i = 0; i < 10; i++) run_cycle(1'b0, '0, 1'b1);
    check_val("seq_count_ok", 32'(deliv_addr.size() >= 3), 32'd1);
    if (deliv_addr.size() >= 3) begin
      for (int i = 0; i < 3; i++) check_val("seq_addr", 32'(deliv_addr[i]), 32'(i));
      check_val("seq_spacing_1", 32'(deliv_cyc[1] - deliv_cyc[0]), 32'd3);
      check_val("seq_spacing_2", 32'(deliv_cyc[2] - deliv_cyc[1]), 32'd3);
    end

    // backpressure in HOLD
    for (int i = 0; i < 20 && !m_have; i++) run_cycle(1'b0, '0, 1'b0);
    check_val("bp_reach_hold", 32'(m_have), 32'd1);
    r0 = read_n;
    for (int i = 0; i < 5; i++) run_cycle(1'b0, '0, 1'b0);
    check_val("bp_no_read", 32'(read_n), 32'(r0));
    run_cycle(1'b0, '0, 1'b1);

    // branch while waiting on a slow response
    lat_cfg = 3;
    for (int i = 0; i < 20 && !(m_out && !m_drop); i++) run_cycle(1'b0, '0, 1'b1);
    check_val("br_reach_wait", 32'(m_out && !m_drop), 32'd1);
    run_cycle(1'b1, 15'h0123, 1'b1);
    r0 = read_n;
    for (int i = 0; i < 20 && read_n == r0; i++) run_cycle(1'b0, '0, 1'b1);
    check_val("br_new_read", 32'(read_n > r0), 32'd1);
    check_val("br_new_addr", 32'(last_read_addr), 32'h0123);

    // halt word at address 2
    lat_cfg = 1; plant_halt = 1'b1;
    apply_reset();
    deliv_addr.delete(); deliv_cyc.delete();
    for (int i = 0; i < 40 && !(deliv_addr.size() > 0 && deliv_addr[$] == 15'd2); i++)
      run_cycle(1'b0, '0, 1'b1);
    check_val("halt_word_delivered", 32'(deliv_addr.size() > 0 && deliv_addr[$] == 15'd2), 32'd1);
    halted_cyc = 0; r0 = read_n;
    for (int i = 0; i < 10; i++) run_cycle(1'b0, '0, 1'b1);
`ifdef FETCH_HALT_EN
    check_val("halt_cycles", 32'(halted_cyc), 32'd10);
    check_val("halt_no_read", 32'(read_n), 32'(r0));
    run_cycle(1'b1, '0, 1'b1);
    r0 = read_n;
    for (int i = 0; i < 10 && read_n == r0; i++) run_cycle(1'b0, '0, 1'b1);
    check_val("halt_resume_addr", 32'(last_read_addr), 32'd0);
`else
    check_val("halt_off_halted", 32'(halted_cyc), 32'd0);
    check_val("halt_off_keeps_fetching", 32'(read_n > r0), 32'd1);
`endif
    plant_halt = 1'b0;

    // randomized traffic
    lat_cfg = 0;
    deliv_addr.delete(); deliv_cyc.delete();
    for (int i = 0; i < 2500; i++) begin
      tgt = ($urandom_range(0, 15) == 0) ? 15'h6FFF : 15'($urandom_range(0, 63));
      run_cycle($urandom_range(0, 7) == 0, tgt, $urandom_range(0, 3) != 0);
    end
    check_val("rand_progress", 32'(deliv_addr.size() > 50), 32'd1);

    // asynchronous reset while waiting for memory
    lat_cfg = 3;
    for (int i = 0; i < 20 && !(m_out && !m_drop && !m_have && !m_halt); i++)
      run_cycle(1'b0, '0, 1'b1);
    check_val("mid_reach_wait", 32'(m_out && !m_drop && !m_have && !m_halt), 32'd1);
    branch_valid = 1'b0; mem_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midwait");
    model_clear();
    @(posedge clock);
    #1;
    check_reset_outputs("midwait_hold");
    @(posedge clock);
    #1 reset = 1'b1;
    lat_cfg = 1;
    for (int i = 0; i < 12; i++) run_cycle(1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
